util_dec_framer: RTL and testbench
==================================

Name: util_dec_framer

Overview:
- Sits directly downstream of util_fir_dec and consumes its decimated 32-bit sample stream ({CH1,CH0}).
- The FIR output has no tready, so this block absorbs it in a small FIFO.
- It re-emits the samples as a back-pressurable AXI-Stream with tlast framing every FRAME_LEN accepted samples, ready for a DMA.
- Samples that cannot be stored are dropped, and the drop is reported through a sticky overflow flag.

Parameters:
- DATA_WIDTH, 32, sample width ({CH1[15:0],CH0[15:0]}).
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, >= 2.
- FRAME_LEN, 120, accepted samples per frame; >= 1.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- enable  in  1  accept input samples when 1; frame counter is held cleared when 0.
- s_axis_data_tvalid  in  1  sample strobe from util_fir_dec m_axis_data_tvalid.
- s_axis_data_tdata  in  DATA_WIDTH  sample from util_fir_dec m_axis_data_tdata.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tlast  out  1  last sample of a frame.
- overflow  out  1  sticky: at least one input sample was dropped.
- clear_overflow  in  1  single-cycle pulse that clears overflow.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, fifo_level=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - overflow=0, frame counter=0.
  - Reset mid-operation discards FIFO contents and any partial frame.
- Write condition: wr = s_axis_data_tvalid & enable & (!full | rd).
  - Write while full is allowed only in the same cycle as a read.
- Read condition: rd = m_axis_tvalid & m_axis_tready.
- Drop: s_axis_data_tvalid & enable & full & !rd.
  - The sample is discarded and overflow is set on the next edge.
  - The frame counter does not advance.
- Samples with enable=0 are ignored silently: no overflow, no counter change.
- Frame counter (0..FRAME_LEN-1):
  - Advances on every wr and wraps to 0 after FRAME_LEN-1.
  - The tlast bit is computed at write time (counter==FRAME_LEN-1) and stored alongside the data as DATA_WIDTH+1 bits per entry.
  - Frames therefore count accepted samples only.
  - enable=0 forces the counter to 0; a partial frame in the FIFO drains without tlast.
- Output is first-word-fall-through and registered:
  - m_axis_tvalid = FIFO non-empty.
  - A sample written at edge k is visible at the outputs after edge k (1-cycle latency) when the FIFO was empty.
- AXI-S rules:
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - tvalid is never deasserted without a read.
- Occupancy:
  - fifo_level increments on wr-only, decrements on rd-only, and is unchanged on simultaneous wr+rd.
  - Range is 0..FIFO_DEPTH.
  - full = (level==FIFO_DEPTH); empty = (level==0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow priority: a set (drop) in the same cycle as clear_overflow wins, so overflow stays 1.
- Data ordering is strictly FIFO; samples pass through unmodified, with no arithmetic.

Test Plan:
1. enable=1, m_axis_tready=1; drive 120 samples 0x00010000+i, one every 8 cycles.
   -> 120 outputs equal to the inputs in order, each appearing 1 cycle after its write.
   -> m_axis_tlast=1 only on sample 119; fifo_level never exceeds 1; overflow=0.
2. m_axis_tready=0; drive 17 back-to-back samples 0..16.
   -> fifo_level=16, sample 16 dropped, overflow=1.
   -> Raise tready: exactly 16 outputs 0..15, then tvalid=0 and level=0.
3. FIFO full (level=16) with m_axis_tready=1 and s_axis_data_tvalid=1 in the same cycle.
   -> New sample accepted, level stays 16, overflow stays 0, and the new sample emerges after the 15 remaining older ones.
4. overflow=1; pulse clear_overflow alone -> overflow=0 next cycle.
   -> Repeat with a drop in the same cycle as clear_overflow -> overflow stays 1.
5. Accept 50 samples, drop enable for 10 cycles with s_axis_data_tvalid=1, then re-enable.
   -> None of the 10 samples is stored and overflow=0.
   -> The 50 buffered samples drain with no tlast; the first tlast appears on the 120th sample accepted after re-enable.
6. Fill to level 7 with tready=0, then assert areset mid-cycle.
   -> m_axis_tvalid=0 and fifo_level=0 immediately (asynchronous), overflow=0.
   -> After release, the first frame's tlast falls on its 120th accepted sample.

Source files
------------

// File: rtl/util_dec_framer.sv
// -----------------------------------------------------------------------------
// util_dec_framer
//
// Purpose:
//   Buffers the decimated sample stream from util_fir_dec, which cannot be
//   stalled, in a small first-word-fall-through FIFO. Samples leave as a
//   back-pressurable AXI-Stream with tlast marking every FRAME_LEN-th
//   accepted sample. A sample that arrives while the FIFO is full and is not
//   being drained is dropped, and a sticky overflow flag is raised.
//
// Ports:
//   aclk, areset          clock and asynchronous active-high reset
//   enable                accept input samples; 0 holds the frame counter at 0
//   s_axis_data_tvalid/   input sample strobe and data ({CH1,CH0}); no ready
//   s_axis_data_tdata
//   m_axis_tvalid/tready/ output AXI-Stream
//   tdata/tlast
//   overflow              sticky drop indicator
//   clear_overflow        single-cycle pulse clearing overflow
//   fifo_level            current FIFO occupancy (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module util_dec_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 120
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic                          s_axis_data_tvalid,
  input  logic [DATA_WIDTH-1:0]         s_axis_data_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Each entry carries the sample plus its tlast bit in the MSB.
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic                full;
  logic                empty;
  logic                wr;
  logic                rd;
  logic                drop;
  logic                last_in;
  logic [DATA_WIDTH:0] head;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign rd      = m_axis_tvalid & m_axis_tready;
  // When full, a write is only legal because the read frees the head slot;
  // wptr equals rptr then, so the new entry lands in the slot being consumed.
  assign wr      = s_axis_data_tvalid & enable & (~full | rd);
  assign drop    = s_axis_data_tvalid & enable & full & ~rd;
  assign last_in = (cnt_q == CW'(FRAME_LEN - 1));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (wr) wptr_d = wptr_q + AW'(1);
    if (rd) rptr_d = rptr_q + AW'(1);

    if (wr && !rd)      level_d = level_q + LW'(1);
    else if (rd && !wr) level_d = level_q - LW'(1);

    // Frames count accepted samples only; disabling restarts the frame.
    if (!enable)      cnt_d = '0;
    else if (wr)      cnt_d = last_in ? '0 : cnt_q + CW'(1);

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)                ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is data only; emptiness is tracked by the reset control state.
  always_ff @(posedge aclk) begin
    if (wr) mem_q[wptr_q] <= {last_in, s_axis_data_tdata};
  end

  // Outputs come straight from registers. The head entry cannot change while
  // the FIFO is non-empty and unread, which keeps tdata/tlast stable under
  // back-pressure. Outputs are forced to zero when empty so reset values hold.
  assign head          = mem_q[rptr_q];
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = ~empty & head[DATA_WIDTH];
  assign overflow      = ovf_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_util_dec_framer.sv
module tb_util_dec_framer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int FL    = 120;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int OW    = DW + LW + 3;

  logic          aclk = 1'b0;
  logic          areset;
  logic          enable;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          overflow;
  logic          clear_overflow;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model: a queue of stored entries, the count of accepted
  // samples within the current frame, and the sticky flag.
  ent_t mq[$];
  ent_t outq[$];
  int   mcnt;
  bit   movf;

  logic [OW-1:0] obs;
  assign obs = {m_tvalid, m_tlast, m_tdata, fifo_level, overflow};

  util_dec_framer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .enable            (enable),
    .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tdata (s_tdata),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tlast      (m_tlast),
    .overflow          (overflow),
    .clear_overflow    (clear_overflow),
    .fifo_level        (fifo_level)
  );

  always #5 aclk = ~aclk;

  function automatic logic [OW-1:0] expv();
    ent_t h;
    if (mq.size() > 0) h = mq[0];
    else               h = '0;
    return {mq.size() > 0, h.last, h.data, LW'(mq.size()), movf};
  endfunction

  task automatic model_reset();
    mq.delete();
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit en,
                       input bit rdy, input bit clr);
    s_tvalid       = v;
    s_tdata        = d;
    enable         = en;
    m_tready       = rdy;
    clear_overflow = clr;
  endtask

  // One clock: model decides from the inputs in force, then both advance.
  task automatic tick();
    bit   full, rd, wr, drop;
    ent_t e;
    full   = (mq.size() == DEPTH);
    rd     = (mq.size() > 0) && m_tready;
    wr     = s_tvalid && enable && (!full || rd);
    drop   = s_tvalid && enable && full && !rd;
    e.last = (mcnt == FL - 1);
    e.data = s_tdata;
    @(posedge aclk);
    if (rd) outq.push_back(mq.pop_front());
    if (wr) mq.push_back(e);
    if (!enable)  mcnt = 0;
    else if (wr)  mcnt = (mcnt == FL - 1) ? 0 : mcnt + 1;
    if (drop)                movf = 1'b1;
    else if (clear_overflow) movf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 0);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_state obs=%h exp=0", obs);
    end
    @(negedge aclk);
    areset = 1'b0;
    model_reset();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_stream();
    int maxlvl = 0;
    outq.delete();
    for (int i = 0; i < FL; i++) begin
      for (int c = 0; c < 8; c++) begin
        drive(c == 0, 32'h0001_0000 + i, 1, 1, 0);
        tick();
        total++;
        if (obs !== expv()) begin
          bad++;
          $display("FAIL stream_cycle i=%0d c=%0d obs=%h exp=%h", i, c, obs, expv());
        end
        if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      end
    end
    total++;
    if (maxlvl > 1) begin
      bad++;
      $display("FAIL stream_maxlevel got=%0d want<=1", maxlvl);
    end
    total++;
    if (outq.size() != FL) begin
      bad++;
      $display("FAIL stream_count got=%0d want=%0d", outq.size(), FL);
    end
    for (int k = 0; k < outq.size(); k++) begin
      total++;
      if (outq[k] !== {k == FL - 1, 32'h0001_0000 + k}) begin
        bad++;
        $display("FAIL stream_out k=%0d got=%h want=%h", k, outq[k], {k == FL - 1, 32'h0001_0000 + k});
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      drive(1, DW'(i), 1, 0, 0);
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL ovf_fill i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    total++;
    if (fifo_level !== LW'(16) || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_full level=%0d ovf=%b want level=16 ovf=1", fifo_level, overflow);
    end
    outq.delete();
    drive(0, '0, 1, 1, 0);
    for (int i = 0; i < 18; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL ovf_drain i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    total++;
    if (outq.size() != 16 || m_tvalid !== 1'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL ovf_drained n=%0d tvalid=%b level=%0d want 16/0/0", outq.size(), m_tvalid, fifo_level);
    end
    for (int k = 0; k < outq.size(); k++) begin
      total++;
      if (outq[k].data !== DW'(k)) begin
        bad++;
        $display("FAIL ovf_order k=%0d got=%h want=%h", k, outq[k].data, k);
      end
    end
  endtask

  task automatic test_full_rw();
    drive(0, '0, 1, 0, 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h0000_A000 + i, 1, 0, 0);
      tick();
    end
    drive(1, 32'h0000_BEEF, 1, 1, 0);
    tick();
    total++;
    if (fifo_level !== LW'(16) || overflow !== 1'b0 || obs !== expv()) begin
      bad++;
      $display("FAIL full_rw level=%0d ovf=%b want level=16 ovf=0", fifo_level, overflow);
    end
    outq.delete();
    drive(0, '0, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL full_rw_drain i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    total++;
    if (outq.size() != 16 || outq[14].data !== 32'h0000_A00F || outq[15].data !== 32'h0000_BEEF) begin
      bad++;
      $display("FAIL full_rw_order n=%0d last=%h want n=16 last=0000beef", outq.size(), outq[outq.size()-1].data);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 17; i++) begin
      drive(1, $urandom, 1, 0, 0);
      tick();
    end
    drive(0, '0, 1, 0, 1);
    tick();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clear_alone ovf=%b want=0", overflow);
    end
    drive(1, $urandom, 1, 0, 0);
    tick();
    drive(1, $urandom, 1, 0, 1);
    tick();
    total++;
    if (overflow !== 1'b1 || obs !== expv()) begin
      bad++;
      $display("FAIL clear_vs_drop ovf=%b want=1", overflow);
    end
    drive(0, '0, 1, 0, 0);
  endtask

  task automatic test_async_reset();
    drive(0, '0, 1, 1, 0);
    repeat (17) tick();
    drive(0, '0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, $urandom, 1, 0, 0);
      tick();
    end
    drive(0, '0, 1, 0, 0);
    total++;
    if (fifo_level !== LW'(7) || overflow !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre level=%0d ovf=%b want 7/1", fifo_level, overflow);
    end
    #2;
    areset = 1'b1;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0 || m_tdata !== '0) begin
      bad++;
      $display("FAIL arst_now tvalid=%b level=%0d ovf=%b want 0/0/0", m_tvalid, fifo_level, overflow);
    end
    model_reset();
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    outq.delete();
    for (int i = 0; i < FL + 2; i++) begin
      drive(i < FL, $urandom, 1, 1, 0);
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL arst_frame i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    for (int k = 0; k < outq.size(); k++) begin
      total++;
      if (outq[k].last !== (k == FL - 1)) begin
        bad++;
        $display("FAIL arst_tlast k=%0d got=%b want=%b", k, outq[k].last, k == FL - 1);
      end
    end
  endtask

  task automatic test_enable();
    logic [DW-1:0] sent[$];
    drive(0, '0, 0, 1, 0);
    tick();
    outq.delete();
    for (int i = 0; i < 50; i++) begin
      drive(1, $urandom, 1, 1, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, 0, 1, 0);
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL en_off i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    total++;
    if (outq.size() != 50 || fifo_level !== '0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL en_off_state n=%0d level=%0d ovf=%b want 50/0/0", outq.size(), fifo_level, overflow);
    end
    for (int k = 0; k < outq.size(); k++) begin
      total++;
      if (outq[k].last !== 1'b0) begin
        bad++;
        $display("FAIL en_partial_tlast k=%0d got=1 want=0", k);
      end
    end
    outq.delete();
    for (int i = 0; i < FL + 2; i++) begin
      drive(i < FL, $urandom, 1, 1, 0);
      if (i < FL) sent.push_back(s_tdata);
      tick();
    end
    total++;
    if (outq.size() != FL) begin
      bad++;
      $display("FAIL en_frame_count got=%0d want=%0d", outq.size(), FL);
    end
    for (int k = 0; k < outq.size(); k++) begin
      total++;
      if (outq[k] !== {k == FL - 1, sent[k]}) begin
        bad++;
        $display("FAIL en_frame k=%0d got=%h want=%h", k, outq[k], {k == FL - 1, sent[k]});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 19) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    drive(0, '0, 1, 1, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random_drain i=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
  endtask

  initial begin
    areset = 1'b0;
    drive(0, '0, 0, 0, 0);
    model_reset();
    test_reset();
    test_stream();
    test_overflow();
    test_full_rw();
    test_clear();
    test_async_reset();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
